control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the single-bus datapath. Decodes IR opcode fields and steps a fixed T-state sequence per instruction, driving register select/encode strobes (Gra/Grb/Grc, Rin, Rout, BAout), bus-source and load enables, ALU op and memory read/write with a ready handshake. It sits between the instruction register and the register file/ALU/MAR/MDR. BAout makes R0 read as zero for base-address use.

## Interface
Parameters:
- OPW, 5, opcode width (IR[31:27])
- ALUW, 4, alu_op width

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  asynchronous, active-low reset
- ir  in  32  instruction register contents
- mem_ready  in  1  memory completes current Read/Write this cycle
- PCout, Zlowout, MDRout, Cout  out  1 each  bus-source enables
- PCin, IRin, MARin, MDRin, Yin, Zin  out  1 each  register load enables
- IncPC  out  1  ALU computes PC+1
- Read, Write  out  1 each  memory strobes (Read also selects memory→MDR mux)
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select/encode controls
- alu_op  out  ALUW  0=ADD, 1=SUB, 2=AND, 3=OR
- run  out  1  high while executing, low in HALT
- illegal  out  1  sticky, unsupported opcode seen

## Operation
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, nop 11010, halt 11011; all others illegal.
- Moore outputs decoded from state plus latched opcode; only listed signals high, all others 0; alu_op=0 unless stated.
- Fetch (all instructions): T0 PCout,MARin,IncPC,Zin; T1 Zlowout,PCin; T2 Read (held) and MDRin only in the cycle mem_ready=1, stays in T2 until then; T3 MDRout,IRin. Opcode latched from ir at entry to T4.
- add/sub/and/or: T4 Grb,Rout,Yin; T5 Grc,Rout,Zin,alu_op per op; T6 Zlowout,Gra,Rin → T0.
- addi: T4 Grb,Rout,Yin; T5 Cout,Zin,ADD; T6 Zlowout,Gra,Rin → T0.
- ldi: as addi but T4 uses Grb,BAout,Yin.
- ld: T4 Grb,BAout,Yin; T5 Cout,Zin,ADD; T6 Zlowout,MARin; T7 Read held, MDRin in mem_ready cycle, wait; T8 MDRout,Gra,Rin → T0.
- st: T4–T6 as ld; T7 Gra,Rout,MDRin (Read=0, bus→MDR); T8 Write held until mem_ready=1 → T0.
- nop: T3 → T0. halt: T3 → HALT; run=0, all strobes 0, stays until clr.
- illegal opcode: set illegal, go to HALT.
- States: RST, T0–T8, HALT; encoded as one state register; unused encodings → RST.

## Timing
- clr low: immediately state=RST, all outputs 0, run=0, illegal=0, latched opcode=0; effective mid-instruction with no completion of pending memory op.
- First rising edge after clr released: RST → T0, run=1 from T0 onward.
- Zero-wait latency (mem_ready tied high): R-type/addi/ldi 7 cycles, ld/st 9, nop 4, halt 4 to HALT.
- Each low cycle of mem_ready in T2/T7(ld)/T8(st) adds one cycle; strobes held stable during wait.
- mem_ready ignored in all other states.
- MDRin with Read high asserted exactly once per memory read.
- Read and Write never high in same cycle; Rin and Rout never high in same cycle.
- ir changes outside T3→T4 boundary have no effect on the current instruction.

## Test plan
- Reset: clr low mid-T5 of add → outputs all 0 same cycle, run=0; release → T0 next edge with PCout=MARin=IncPC=Zin=1.
- add (ir=0x18000000|fields), mem_ready=1 → 7-cycle trace matches T0–T6 exactly, alu_op=0 in T5; sub gives alu_op=1.
- ld with mem_ready low 3 cycles in T7 → Read high 4 cycles, MDRin high only in final one, total 12 cycles.
- st, mem_ready=1 → T7 MDRin=1 with Read=0, T8 Write=1 one cycle, returns to T0.
- ldi → T4 BAout=1,Grb=1,Rout=0; addi → T4 Rout=1,BAout=0.
- halt (opcode 11011) → run=0 after T3, no strobes for 20 cycles; opcode 11111 → illegal=1, HALT.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus datapath: fetch T0-T3, then a
// per-opcode execute sequence T4-T8, with memory waits held on mem_ready.
module control_sequencer #(
    parameter int OPW  = 5,
    parameter int ALUW = 4
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [31:0]     ir,
    input  logic            mem_ready,
    output logic            PCout,
    output logic            Zlowout,
    output logic            MDRout,
    output logic            Cout,
    output logic            PCin,
    output logic            IRin,
    output logic            MARin,
    output logic            MDRin,
    output logic            Yin,
    output logic            Zin,
    output logic            IncPC,
    output logic            Read,
    output logic            Write,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic [ALUW-1:0] alu_op,
    output logic            run,
    output logic            illegal
);
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_T8, S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    state_t         state, nxt;
    logic [OPW-1:0] opc;
    logic [OPW-1:0] ir_op;
    logic           ir_legal;
    logic           is_mem, is_base, is_rtype;
    logic           ir_unused;

    assign ir_op     = ir[31 -: OPW];
    assign ir_unused = ^ir[31-OPW:0];

    always_comb begin
        ir_legal = 1'b0;
        case (ir_op)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_NOP, OP_HALT: ir_legal = 1'b1;
            default:                  ir_legal = 1'b0;
        endcase
    end

    // Execute-phase decode works only from the opcode captured leaving T3.
    assign is_mem   = (opc == OP_LD) || (opc == OP_ST);
    assign is_base  = is_mem || (opc == OP_LDI);
    assign is_rtype = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= S_RST;
            opc     <= '0;
            illegal <= 1'b0;
        end else begin
            state <= nxt;
            if (state == S_T3) begin
                opc <= ir_op;
                if (!ir_legal) illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        nxt     = state;
        PCout   = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout  = 1'b0;
        PCin    = 1'b0; IRin    = 1'b0; MARin  = 1'b0; MDRin = 1'b0;
        Yin     = 1'b0; Zin     = 1'b0; IncPC  = 1'b0; Read  = 1'b0;
        Write   = 1'b0; Gra     = 1'b0; Grb    = 1'b0; Grc   = 1'b0;
        Rin     = 1'b0; Rout    = 1'b0; BAout  = 1'b0;
        alu_op  = '0;
        run     = 1'b0;
        case (state)
            S_RST: nxt = S_T0;
            S_T0: begin
                run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                nxt = S_T1;
            end
            S_T1: begin
                run = 1'b1; Zlowout = 1'b1; PCin = 1'b1;
                nxt = S_T2;
            end
            S_T2: begin
                run = 1'b1; Read = 1'b1;
                if (mem_ready) begin
                    MDRin = 1'b1;
                    nxt   = S_T3;
                end
            end
            S_T3: begin
                run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
                if (!ir_legal || ir_op == OP_HALT) nxt = S_HALT;
                else if (ir_op == OP_NOP)          nxt = S_T0;
                else                               nxt = S_T4;
            end
            S_T4: begin
                run = 1'b1; Grb = 1'b1; Yin = 1'b1;
                if (is_base) BAout = 1'b1;
                else         Rout  = 1'b1;
                nxt = S_T5;
            end
            S_T5: begin
                run = 1'b1; Zin = 1'b1;
                if (is_rtype) begin
                    Grc = 1'b1; Rout = 1'b1;
                    case (opc)
                        OP_SUB:  alu_op = ALUW'(1);
                        OP_AND:  alu_op = ALUW'(2);
                        OP_OR:   alu_op = ALUW'(3);
                        default: alu_op = ALUW'(0);
                    endcase
                end else begin
                    Cout = 1'b1;
                end
                nxt = S_T6;
            end
            S_T6: begin
                run = 1'b1; Zlowout = 1'b1;
                if (is_mem) begin
                    MARin = 1'b1;
                    nxt   = S_T7;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                    nxt = S_T0;
                end
            end
            S_T7: begin
                run = 1'b1;
                if (opc == OP_ST) begin
                    // Register drives the bus straight into MDR; no memory access.
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    nxt = S_T8;
                end else begin
                    Read = 1'b1;
                    if (mem_ready) begin
                        MDRin = 1'b1;
                        nxt   = S_T8;
                    end
                end
            end
            S_T8: begin
                run = 1'b1;
                if (opc == OP_ST) begin
                    Write = 1'b1;
                    if (mem_ready) nxt = S_T0;
                end else begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    nxt = S_T0;
                end
            end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_RST;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle strobe traces compared
// against hand-written expected vectors for each instruction class.
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] ir  = '0;
    logic        mem_ready = 1'b1;
    logic PCout, Zlowout, MDRout, Cout, PCin, IRin, MARin, MDRin, Yin, Zin, IncPC;
    logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run, illegal;
    logic [3:0] alu_op;
    int errors = 0;
    int checks = 0;

    control_sequencer #(.OPW(5), .ALUW(4)) dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
        .Zin(Zin), .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .alu_op(alu_op), .run(run), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [23:0] obs;
    assign obs = {run, alu_op, PCout, Zlowout, MDRout, Cout, PCin, IRin, MARin,
                  MDRin, Yin, Zin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout};

    localparam logic [23:0] RUN  = 24'd1 << 23;
    localparam logic [23:0] ASUB = 24'd1 << 19;
    localparam logic [23:0] AAND = 24'd2 << 19;
    localparam logic [23:0] AOR  = 24'd3 << 19;
    localparam logic [23:0] PCO  = 24'd1 << 18;
    localparam logic [23:0] ZLO  = 24'd1 << 17;
    localparam logic [23:0] MDRO = 24'd1 << 16;
    localparam logic [23:0] CO   = 24'd1 << 15;
    localparam logic [23:0] PCI  = 24'd1 << 14;
    localparam logic [23:0] IRI  = 24'd1 << 13;
    localparam logic [23:0] MARI = 24'd1 << 12;
    localparam logic [23:0] MDRI = 24'd1 << 11;
    localparam logic [23:0] YIN  = 24'd1 << 10;
    localparam logic [23:0] ZIN  = 24'd1 << 9;
    localparam logic [23:0] INC  = 24'd1 << 8;
    localparam logic [23:0] RD   = 24'd1 << 7;
    localparam logic [23:0] WR   = 24'd1 << 6;
    localparam logic [23:0] GRA  = 24'd1 << 5;
    localparam logic [23:0] GRB  = 24'd1 << 4;
    localparam logic [23:0] GRC  = 24'd1 << 3;
    localparam logic [23:0] RIN  = 24'd1 << 2;
    localparam logic [23:0] ROUT = 24'd1 << 1;
    localparam logic [23:0] BAO  = 24'd1 << 0;

    localparam logic [23:0] F0 = RUN | PCO | MARI | INC | ZIN;
    localparam logic [23:0] F1 = RUN | ZLO | PCI;
    localparam logic [23:0] F2 = RUN | RD | MDRI;
    localparam logic [23:0] F3 = RUN | MDRO | IRI;
    localparam logic [31:0] FIELDS = (32'd1 << 23) | (32'd2 << 19) | (32'd3 << 15) | 32'd5;

    // Pulse clr across one edge and release at a falling edge; the next rising edge enters T0.
    task automatic start(input logic [31:0] instr);
        @(negedge clk); clr = 1'b0; ir = instr; mem_ready = 1'b1;
        @(negedge clk); clr = 1'b1;
    endtask

    task automatic test_reset();
        logic [23:0] e [6] = '{F0, F1, F2, F3, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZIN};
        #1; checks++;
        if (obs !== 24'd0 || illegal !== 1'b0) begin
            errors++; $display("FAIL reset_init got=%h ill=%b want=0", obs, illegal);
        end
        start(32'h18000000 | FIELDS);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1; checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL reset_pre cyc%0d got=%h want=%h", i, obs, e[i]); end
        end
        clr = 1'b0; #1; checks++;
        if (obs !== 24'd0 || illegal !== 1'b0) begin
            errors++; $display("FAIL reset_midT5 got=%h ill=%b want=0", obs, illegal);
        end
        @(negedge clk); #1; checks++;
        if (obs !== 24'd0) begin errors++; $display("FAIL reset_held got=%h want=0", obs); end
        clr = 1'b1;
        @(negedge clk); #1; checks++;
        if (obs !== F0) begin errors++; $display("FAIL reset_release got=%h want=%h", obs, F0); end
    endtask

    task automatic test_add();
        logic [23:0] e [8] = '{F0, F1, F2, F3, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZIN, RUN|ZLO|GRA|RIN, F0};
        start(32'h18000000 | FIELDS);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1; checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL add cyc%0d got=%h want=%h", i, obs, e[i]); end
        end
    endtask

    // ir is swapped to an add after T3; the latched opcode must still steer alu_op.
    task automatic test_alu_ops();
        logic [31:0] ops [3] = '{32'h20000000, 32'h28000000, 32'h30000000};
        logic [23:0] au  [3] = '{ASUB, AAND, AOR};
        logic [23:0] e;
        for (int k = 0; k < 3; k++) begin
            start(ops[k] | FIELDS);
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                if (i == 4) ir = 32'h18000000;
                #1;
                case (i)
                    0: e = F0; 1: e = F1; 2: e = F2; 3: e = F3;
                    4: e = RUN|GRB|ROUT|YIN;
                    5: e = RUN|GRC|ROUT|ZIN|au[k];
                    default: e = RUN|ZLO|GRA|RIN;
                endcase
                checks++;
                if (obs !== e) begin errors++; $display("FAIL alu_op%0d cyc%0d got=%h want=%h", k, i, obs, e); end
            end
        end
    endtask

    task automatic test_ld_wait();
        logic [23:0] e [13] = '{F0, F1, F2, F3, RUN|GRB|BAO|YIN, RUN|CO|ZIN, RUN|ZLO|MARI,
                                RUN|RD, RUN|RD, RUN|RD, RUN|RD|MDRI, RUN|MDRO|GRA|RIN, F0};
        logic mr [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        start(32'h00000000 | FIELDS);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk); mem_ready = mr[i]; #1; checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL ld_wait cyc%0d got=%h want=%h", i, obs, e[i]); end
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_st();
        logic [23:0] e [10] = '{F0, F1, F2, F3, RUN|GRB|BAO|YIN, RUN|CO|ZIN, RUN|ZLO|MARI,
                                RUN|GRA|ROUT|MDRI, RUN|WR, F0};
        start(32'h10000000 | FIELDS);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1; checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL st cyc%0d got=%h want=%h", i, obs, e[i]); end
        end
    endtask

    task automatic test_ldi_addi();
        logic [23:0] e [8];
        e = '{F0, F1, F2, F3, RUN|GRB|BAO|YIN, RUN|CO|ZIN, RUN|ZLO|GRA|RIN, F0};
        start(32'h08000000 | FIELDS);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1; checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL ldi cyc%0d got=%h want=%h", i, obs, e[i]); end
        end
        e = '{F0, F1, F2, F3, RUN|GRB|ROUT|YIN, RUN|CO|ZIN, RUN|ZLO|GRA|RIN, F0};
        start(32'h60000000 | FIELDS);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1; checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL addi cyc%0d got=%h want=%h", i, obs, e[i]); end
        end
    endtask

    // nop with a one-cycle fetch wait; mem_ready low outside T2 must not stall.
    task automatic test_nop_fetch_wait();
        logic [23:0] e [6] = '{F0, F1, RUN|RD, F2, F3, F0};
        logic mr [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        start(32'hD0000000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); mem_ready = mr[i]; #1; checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL nop cyc%0d got=%h want=%h", i, obs, e[i]); end
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_halt();
        logic [23:0] e [4] = '{F0, F1, F2, F3};
        int bad = 0;
        start(32'hD8000000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1; checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL halt_fetch cyc%0d got=%h want=%h", i, obs, e[i]); end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); mem_ready = i[0]; #1;
            if (obs !== 24'd0 || illegal !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL halt_idle bad_cycles=%0d want=0", bad); end
        mem_ready = 1'b1;
    endtask

    task automatic test_illegal();
        logic [23:0] e [4] = '{F0, F1, F2, F3};
        start(32'hF8000000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1; checks++;
            if (obs !== e[i] || illegal !== 1'b0) begin
                errors++; $display("FAIL illegal_fetch cyc%0d got=%h ill=%b want=%h ill=0", i, obs, illegal, e[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); ir = 32'h18000000; #1; checks++;
            if (obs !== 24'd0 || illegal !== 1'b1) begin
                errors++; $display("FAIL illegal_halt cyc%0d got=%h ill=%b want=0 ill=1", i, obs, illegal);
            end
        end
        @(negedge clk); clr = 1'b0; #1; checks++;
        if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear got=%b want=0", illegal); end
        clr = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_ld_wait();
        test_st();
        test_ldi_addi();
        test_nop_fetch_wait();
        test_halt();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
